// File: rtl/dsp_i2s_dac_tx_if.sv
// Sample handoff between the DSP chain (master) and the I2S DAC transmitter (slave).
interface dsp_i2s_dac_tx_if #(
   parameter int unsigned ws = 16
);
   logic [ws-1:0] iLeft;
   logic [ws-1:0] iRight;
   logic          iValid;
   logic          oReady;

   modport master (output iLeft, output iRight, output iValid, input oReady);
   modport slave  (input iLeft, input iRight, input iValid, output oReady);
endinterface

// File: rtl/dsp_i2s_dac_tx.sv
// I2S master transmitter: generates BCLK/LRCK, double-buffers one stereo
// sample (staging -> shift) and strobes the DSP chain once per frame.
module dsp_i2s_dac_tx #(
   parameter int unsigned ws        = 16,
   parameter int unsigned SLOT      = 32,
   parameter int unsigned BCLK_HALF = 4
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   dsp_i2s_dac_tx_if.slave smp,
   input  logic            iMute,
   output logic            oBCLK,
   output logic            oLRCK,
   output logic            oDACDAT,
   output logic            oFrameStrobe,
   output logic [15:0]     oUnderrunCnt
);

   localparam int unsigned FRAME = 2 * SLOT;
   localparam int unsigned DIV_W = $clog2(BCLK_HALF);
   localparam int unsigned CNT_W = $clog2(FRAME);
   localparam int unsigned IDX_W = $clog2(2 * ws);
   localparam int unsigned SMP_W = 2 * ws;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME - 1);
   localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT);
   localparam logic [CNT_W-1:0] WS_C     = CNT_W'(ws);
   localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      RUN        = 1'b1
   } state_t;

   state_t             state;
   state_t             stateNxt;

   logic [DIV_W-1:0]   div;
   logic [CNT_W-1:0]   bitcnt;
   logic [SMP_W-1:0]   staging;
   logic [SMP_W-1:0]   shift;
   logic [SMP_W-1:0]   last;

   logic               divWrap;
   logic               fallEv;
   logic               frameStart;
   logic [CNT_W-1:0]   bitcntNxt;
   logic               rightSlot;
   logic [CNT_W-1:0]   pos;
   logic [CNT_W-1:0]   offs;
   logic [IDX_W-1:0]   bitIdx;
   logic               inData;
   logic               dataBit;

   logic               loadStaging;
   logic               loadLast;
   logic               loadZero;
   logic               countUnderrun;

   // Bit-clock divider events and the serial bit for the upcoming slot position
   always_comb begin
      divWrap    = (div == DIV_LAST);
      fallEv     = divWrap & oBCLK;
      frameStart = fallEv & (bitcnt == BIT_LAST);
      bitcntNxt  = (bitcnt == BIT_LAST) ? '0 : bitcnt + CNT_W'(1);
      rightSlot  = (bitcntNxt >= SLOT_C);
      pos        = rightSlot ? bitcntNxt - SLOT_C : bitcntNxt;
      inData     = (pos != '0) && (pos <= WS_C);
      offs       = WS_C - pos;
      bitIdx     = rightSlot ? IDX_W'(offs) : IDX_W'(offs) + IDX_W'(ws);
      dataBit    = inData & shift[bitIdx];
   end

   // FSM state register
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state <= WAIT_FIRST;
      end else begin
         state <= stateNxt;
      end
   end

   // Frame-start decision: load fresh sample, repeat last (underrun) or send silence
   always_comb begin
      stateNxt      = state;
      loadStaging   = 1'b0;
      loadLast      = 1'b0;
      loadZero      = 1'b0;
      countUnderrun = 1'b0;
      if (frameStart) begin
         if (!smp.oReady) begin
            loadStaging = 1'b1;
            stateNxt    = RUN;
         end else if (state == RUN) begin
            loadLast      = 1'b1;
            countUnderrun = 1'b1;
         end else begin
            loadZero = 1'b1;
         end
      end
   end

   // Clock generation, serialiser, sample buffering and underrun counter
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         div          <= '0;
         oBCLK        <= 1'b0;
         oLRCK        <= 1'b1;
         oDACDAT      <= 1'b0;
         oFrameStrobe <= 1'b0;
         oUnderrunCnt <= '0;
         bitcnt       <= BIT_LAST;
         staging      <= '0;
         shift        <= '0;
         last         <= '0;
         smp.oReady   <= 1'b1;
      end else begin
         if (divWrap) begin
            div   <= '0;
            oBCLK <= ~oBCLK;
         end else begin
            div <= div + DIV_W'(1);
         end

         oFrameStrobe <= frameStart;

         if (fallEv) begin
            bitcnt  <= bitcntNxt;
            oLRCK   <= rightSlot;
            oDACDAT <= dataBit;
         end

         if (loadStaging) begin
            shift      <= iMute ? '0 : staging;
            last       <= staging;
            smp.oReady <= 1'b1;
         end else if (loadLast) begin
            shift <= iMute ? '0 : last;
         end else if (loadZero) begin
            shift <= '0;
         end

         if (countUnderrun && (oUnderrunCnt != CNT_MAX)) begin
            oUnderrunCnt <= oUnderrunCnt + 16'd1;
         end

         // Capture only while empty; the frame-start load above saw the pre-capture state
         if (smp.iValid && smp.oReady) begin
            staging    <= {smp.iLeft, smp.iRight};
            smp.oReady <= 1'b0;
         end
      end
   end

endmodule
